// File: rtl/d_out_arbiter.sv
// Drains the D0/D1 destination FIFOs into one valid/ready stream tagged with the source channel.
// Round-robin pop arbitration, 2-entry holding buffer, per-channel delivery counters and idle/active status.
module d_out_arbiter #(
  parameter int DATA_SIZE = 6,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty_d0,
  input  logic                 fifo_empty_d1,
  input  logic [DATA_SIZE-1:0] data_out_0,
  input  logic [DATA_SIZE-1:0] data_out_1,
  input  logic                 sink_ready,
  output logic                 pop_d0,
  output logic                 pop_d1,
  output logic                 valid_out,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 dest_out,
  output logic [CNT_W-1:0]     cnt_d0,
  output logic [CNT_W-1:0]     cnt_d1,
  output logic                 idle_out,
  output logic                 active_out
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_e;

  typedef struct packed {
    logic                 dest;
    logic [DATA_SIZE-1:0] data;
  } entry_t;

  entry_t         buf_q [2];
  logic           wr_ptr_q, rd_ptr_q;
  logic [1:0]     occ_q, occ_d;
  logic           inflight_q, inflight_dest_q;
  logic           last_grant_q;
  logic [CNT_W-1:0] cnt_d0_q, cnt_d1_q;
  state_e         state_q;

  logic xfer, pop_allowed, pop_any, have_d0, have_d1;

  assign valid_out  = (occ_q != 2'd0);
  assign data_out   = buf_q[rd_ptr_q].data;
  assign dest_out   = buf_q[rd_ptr_q].dest;
  assign cnt_d0     = cnt_d0_q;
  assign cnt_d1     = cnt_d1_q;
  assign idle_out   = (state_q == S_IDLE);
  assign active_out = (state_q == S_ACTIVE);

  assign xfer    = valid_out && sink_ready;
  assign have_d0 = !fifo_empty_d0;
  assign have_d1 = !fifo_empty_d1;

  // A slot is free when buffered + in-flight words leave room, counting the head leaving this cycle.
  assign pop_allowed = ({1'b0, occ_q} + {2'b00, inflight_q}) <= (3'd1 + {2'b00, xfer});
  assign pop_any     = pop_d0 || pop_d1;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    pop_d0 = 1'b0;
    pop_d1 = 1'b0;
    if (!reset && pop_allowed) begin
      if (have_d0 && have_d1) begin
        if (last_grant_q) pop_d0 = 1'b1;
        else              pop_d1 = 1'b1;
      end else if (have_d0) begin
        pop_d0 = 1'b1;
      end else if (have_d1) begin
        pop_d1 = 1'b1;
      end
    end
  end

  always_comb begin
    occ_d = occ_q + {1'b0, inflight_q} - {1'b0, xfer};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the holding buffer is reset because its head drives data_out, which must read 0 after reset.
      buf_q[0]        <= '0;
      buf_q[1]        <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      occ_q           <= 2'd0;
      inflight_q      <= 1'b0;
      inflight_dest_q <= 1'b0;
      last_grant_q    <= 1'b1;
      cnt_d0_q        <= '0;
      cnt_d1_q        <= '0;
      state_q         <= S_IDLE;
    end else begin
      if (inflight_q) begin
        buf_q[wr_ptr_q] <= '{dest: inflight_dest_q,
                             data: inflight_dest_q ? data_out_1 : data_out_0};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (xfer) begin
        rd_ptr_q <= ~rd_ptr_q;
        if (dest_out) cnt_d1_q <= cnt_d1_q + 1'b1;
        else          cnt_d0_q <= cnt_d0_q + 1'b1;
      end
      occ_q           <= occ_d;
      inflight_q      <= pop_any;
      inflight_dest_q <= pop_d1;
      if (pop_any) last_grant_q <= pop_d1;

      case (state_q)
        S_IDLE:   if (have_d0 || have_d1) state_q <= S_ACTIVE;
        S_ACTIVE: if (!have_d0 && !have_d1 && !inflight_q && (occ_q == {1'b0, xfer}))
                    state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_d_out_arbiter.sv
// Randomized and directed bench for d_out_arbiter: FIFO models feed the DUT, a scoreboard queue holds
// popped words, and a negedge monitor checks outputs against a spec-level model of occupancy and arbitration.
module tb_d_out_arbiter;

  localparam int DW = 6;

  typedef struct {
    bit          dest;
    logic [DW-1:0] data;
  } item_t;

  typedef struct {
    int cyc;
    bit ch;
  } pop_rec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_empty_d0 = 1'b1, fifo_empty_d1 = 1'b1;
  logic [DW-1:0] data_out_0 = '0, data_out_1 = '0;
  logic          sink_ready = 1'b1;

  logic          pop_d0, pop_d1, valid_out, dest_out, idle_out, active_out;
  logic [DW-1:0] data_out;
  logic [7:0]    cnt_d0, cnt_d1;

  logic          pop_d0_b, pop_d1_b, valid_out_b, dest_out_b, idle_out_b, active_out_b;
  logic [DW-1:0] data_out_b;
  logic [1:0]    cnt_d0_b, cnt_d1_b;

  d_out_arbiter #(.DATA_SIZE(DW), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset),
    .fifo_empty_d0(fifo_empty_d0), .fifo_empty_d1(fifo_empty_d1),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .sink_ready(sink_ready),
    .pop_d0(pop_d0), .pop_d1(pop_d1), .valid_out(valid_out), .data_out(data_out),
    .dest_out(dest_out), .cnt_d0(cnt_d0), .cnt_d1(cnt_d1),
    .idle_out(idle_out), .active_out(active_out)
  );

  // Narrow-counter instance sharing the same stimulus, used to observe counter wrap.
  d_out_arbiter #(.DATA_SIZE(DW), .CNT_W(2)) u_dut_w2 (
    .clk(clk), .reset(reset),
    .fifo_empty_d0(fifo_empty_d0), .fifo_empty_d1(fifo_empty_d1),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .sink_ready(sink_ready),
    .pop_d0(pop_d0_b), .pop_d1(pop_d1_b), .valid_out(valid_out_b), .data_out(data_out_b),
    .dest_out(dest_out_b), .cnt_d0(cnt_d0_b), .cnt_d1(cnt_d1_b),
    .idle_out(idle_out_b), .active_out(active_out_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // FIFO contents, scoreboard and logs
  logic [DW-1:0] q0[$], q1[$];
  item_t         exp_q[$];
  pop_rec_t      pop_log[$];
  int            xfer_log[$];
  int            cyc = 0;
  int            ready_mode = 1;  // 0 low, 1 high, 2 toggle
  bit            pop0_seen = 0, pop1_seen = 0;

  // Spec-level model state
  int m_occ = 0;
  bit m_inflight = 0;
  bit m_last = 1;
  bit m_idle = 1;
  int m_cnt0 = 0, m_cnt1 = 0;

  // FIFO model: a pop seen in cycle k updates read data and empty flag in cycle k+1.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pop0_seen && q0.size() > 0) begin
        data_out_0 = q0.pop_front();
        exp_q.push_back('{dest: 1'b0, data: data_out_0});
      end
      if (pop1_seen && q1.size() > 0) begin
        data_out_1 = q1.pop_front();
        exp_q.push_back('{dest: 1'b1, data: data_out_1});
      end
      fifo_empty_d0 = (q0.size() == 0);
      fifo_empty_d1 = (q1.size() == 0);
      case (ready_mode)
        0:       sink_ready = 1'b0;
        1:       sink_ready = 1'b1;
        default: sink_ready = ~sink_ready;
      endcase
    end
  end

  bit mx_xfer, mx_allowed, mx_h0, mx_h1, mx_any, mx_ch;
  item_t mx_item;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        check("pop_during_reset", {30'd0, pop_d0, pop_d1}, 32'd0);
        exp_q.delete();
        m_occ = 0; m_inflight = 0; m_last = 1; m_idle = 1; m_cnt0 = 0; m_cnt1 = 0;
        pop0_seen = 0; pop1_seen = 0;
      end else begin
        check("valid_out", {31'd0, valid_out}, {31'd0, m_occ != 0});
        if (m_occ != 0) begin
          if (exp_q.size() == 0) check("scoreboard_empty", 32'd0, 32'd1);
          else begin
            check("data_out", {26'd0, data_out}, {26'd0, exp_q[0].data});
            check("dest_out", {31'd0, dest_out}, {31'd0, exp_q[0].dest});
          end
        end
        check("cnt_d0", {24'd0, cnt_d0}, m_cnt0 % 256);
        check("cnt_d1", {24'd0, cnt_d1}, m_cnt1 % 256);
        check("cnt_d0_w2", {30'd0, cnt_d0_b}, m_cnt0 % 4);
        check("cnt_d1_w2", {30'd0, cnt_d1_b}, m_cnt1 % 4);
        check("idle_out", {31'd0, idle_out}, {31'd0, m_idle});
        check("active_out", {31'd0, active_out}, {31'd0, !m_idle});

        mx_xfer    = (m_occ != 0) && sink_ready;
        mx_allowed = (2 - m_occ - int'(m_inflight) + int'(mx_xfer)) >= 1;
        mx_h0      = !fifo_empty_d0;
        mx_h1      = !fifo_empty_d1;
        mx_any     = mx_allowed && (mx_h0 || mx_h1);
        mx_ch      = (mx_h0 && mx_h1) ? !m_last : mx_h1;
        check("pop_d0", {31'd0, pop_d0}, {31'd0, mx_any && !mx_ch});
        check("pop_d1", {31'd0, pop_d1}, {31'd0, mx_any && mx_ch});
        pop0_seen = pop_d0;
        pop1_seen = pop_d1;
        if (pop_d0 || pop_d1) pop_log.push_back('{cyc: cyc, ch: pop_d1});

        if (m_inflight && m_occ == 2 && !mx_xfer) check("write_into_full", 32'd1, 32'd0);
        if (mx_xfer) begin
          if (exp_q.size() > 0) mx_item = exp_q.pop_front();
          if (mx_item.dest) m_cnt1++; else m_cnt0++;
          xfer_log.push_back(cyc);
        end
        if (m_idle && (mx_h0 || mx_h1)) m_idle = 0;
        else if (!m_idle && !mx_h0 && !mx_h1 && !m_inflight && (m_occ - int'(mx_xfer)) == 0) m_idle = 1;
        m_occ = m_occ + int'(m_inflight) - int'(mx_xfer);
        m_inflight = mx_any;
        if (mx_any) m_last = mx_ch;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    pop_log.delete();
    xfer_log.delete();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && fifo_empty_d0 && fifo_empty_d1 &&
             m_occ == 0 && !m_inflight && exp_q.size() == 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drain_timeout"}, {31'd0, n < budget}, 32'd1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;

    // Single channel, consecutive pops and outputs
    do_reset();
    ready_mode = 1;
    q0.push_back(6'h05); q0.push_back(6'h06); q0.push_back(6'h07);
    drain("t1", 100);
    check("t1_pops", pop_log.size(), 32'd3);
    check("t1_xfers", xfer_log.size(), 32'd3);
    if (pop_log.size() == 3 && xfer_log.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("t1_pop_ch", {31'd0, pop_log[i].ch}, 32'd0);
        check("t1_pop_cyc", pop_log[i].cyc, pop_log[0].cyc + i);
        check("t1_xfer_cyc", xfer_log[i], pop_log[0].cyc + 2 + i);
      end
    end
    check("t1_cnt_d0", {24'd0, cnt_d0}, 32'd3);
    check("t1_idle", {31'd0, idle_out}, 32'd1);

    // Both channels alternate starting with D0
    do_reset();
    q0.push_back(6'h01); q0.push_back(6'h02);
    q1.push_back(6'h21); q1.push_back(6'h22);
    drain("t2", 100);
    check("t2_pops", pop_log.size(), 32'd4);
    if (pop_log.size() == 4)
      for (int i = 0; i < 4; i++) check("t2_pop_order", {31'd0, pop_log[i].ch}, i % 2);
    check("t2_cnt_d0", {24'd0, cnt_d0}, 32'd2);
    check("t2_cnt_d1", {24'd0, cnt_d1}, 32'd2);

    // Back-pressure: only two words outstanding
    do_reset();
    ready_mode = 0;
    for (int i = 0; i < 5; i++) q0.push_back(6'(8'h10 + i));
    repeat (12) @(posedge clk);
    #2;
    check("t3_pops_stalled", pop_log.size(), 32'd2);
    check("t3_valid_held", {31'd0, valid_out}, 32'd1);
    ready_mode = 1;
    drain("t3", 100);
    check("t3_xfers", xfer_log.size(), 32'd5);

    // Toggling ready, random words on both channels
    do_reset();
    ready_mode = 2;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(1) == 1) q1.push_back(6'($urandom_range(63)));
      else                        q0.push_back(6'($urandom_range(63)));
      repeat ($urandom_range(2)) @(posedge clk);
      #2;
    end
    drain("t4", 400);
    check("t4_xfers", xfer_log.size(), 32'd20);
    ready_mode = 1;

    // Counter wrap on the 2-bit instance
    do_reset();
    for (int i = 0; i < 5; i++) q1.push_back(6'(8'h28 + i));
    drain("t5", 100);
    check("t5_cnt_d1_wrap", {30'd0, cnt_d1_b}, 32'd1);
    check("t5_cnt_d1", {24'd0, cnt_d1}, 32'd5);

    // Reset with one word buffered and one in flight
    do_reset();
    ready_mode = 0;
    q0.push_back(6'h31); q0.push_back(6'h32); q0.push_back(6'h33);
    begin
      int n = 0;
      while (pop_log.size() < 2 && n < 50) begin
        @(negedge clk); #1;
        n++;
      end
      check("t6_wait_pops", {31'd0, n < 50}, 32'd1);
    end
    @(posedge clk); #2;
    reset = 1'b1;
    q1.push_back(6'h3A);
    @(posedge clk); #2;
    reset = 1'b0;
    ready_mode = 1;
    pop_log.delete();
    xfer_log.delete();
    @(negedge clk); #1;
    check("t6_valid_after_reset", {31'd0, valid_out}, 32'd0);
    check("t6_cnt_d0_after_reset", {24'd0, cnt_d0}, 32'd0);
    check("t6_idle_after_reset", {31'd0, idle_out}, 32'd1);
    drain("t6", 100);
    check("t6_pops", pop_log.size(), 32'd2);
    if (pop_log.size() > 0) check("t6_first_grant", {31'd0, pop_log[0].ch}, 32'd0);
    check("t6_xfers", xfer_log.size(), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
